// File: rtl/mux_scan_sel.sv
// Registered N-channel selector with a manual / one-pass scan / round-robin sequencer
// and a valid/ready output handshake toward a single consumer.
module mux_scan_sel #(
    parameter int W  = 1,
    parameter int CH = 16,
    localparam int SW = $clog2(CH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CH*W-1:0] in_data,
    input  logic [1:0]      mode,
    input  logic [SW-1:0]   sel,
    input  logic [CH-1:0]   mask,
    input  logic            start,
    input  logic            abort,
    output logic [W-1:0]    out_data,
    output logic [SW-1:0]   out_ch,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [1:0] MODE_SCAN = 2'b01;
    localparam logic [1:0] MODE_CONT = 2'b10;

    state_t          state_reg;
    logic [1:0]      mode_reg;
    logic [CH-1:0]   mask_reg;
    logic [W-1:0]    out_data_reg;
    logic [SW-1:0]   out_ch_reg;
    logic            out_valid_reg;
    logic            busy_reg;
    logic            done_reg;

    logic [W-1:0]    chan [CH];
    logic [1:0]      mode_eff;
    logic [CH-1:0]   mask_eff;
    logic            is_scan;
    logic            is_cont;
    logic            first_found;
    logic [SW-1:0]   first_idx;
    logic            after_found;
    logic [SW-1:0]   after_idx;
    logic [SW-1:0]   load_idx_next;
    logic [W-1:0]    load_data_next;
    logic            handshake;

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_chan
            assign chan[gi] = in_data[gi*W +: W];
        end
    endgenerate

    // In IDLE the search runs on the live inputs so the first channel loads on the start edge.
    assign mode_eff  = (state_reg == IDLE) ? mode : mode_reg;
    assign mask_eff  = (state_reg == IDLE) ? mask : mask_reg;
    assign is_scan   = (mode_eff == MODE_SCAN);
    assign is_cont   = (mode_eff == MODE_CONT);
    assign handshake = out_valid_reg & out_ready;

    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        after_found = 1'b0;
        after_idx   = '0;
        for (int k = CH - 1; k >= 0; k--) begin
            if (mask_eff[k]) begin
                first_found = 1'b1;
                first_idx   = SW'(k);
            end
            if (mask_eff[k] && (k > int'(out_ch_reg))) begin
                after_found = 1'b1;
                after_idx   = SW'(k);
            end
        end
    end

    always_comb begin
        load_idx_next = sel;
        if (is_scan || is_cont) begin
            if (state_reg == IDLE || !after_found) begin
                load_idx_next = first_idx;
            end else begin
                load_idx_next = after_idx;
            end
        end
        // An out-of-range manual select still produces a valid capture of zero.
        load_data_next = (int'(load_idx_next) < CH) ? chan[load_idx_next] : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            mode_reg      <= '0;
            mask_reg      <= '0;
            out_data_reg  <= '0;
            out_ch_reg    <= '0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        mode_reg <= mode;
                        mask_reg <= mask;
                        if ((is_scan || is_cont) && !first_found) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg     <= PRESENT;
                            out_data_reg  <= load_data_next;
                            out_ch_reg    <= load_idx_next;
                            out_valid_reg <= 1'b1;
                            busy_reg      <= 1'b1;
                        end
                    end
                end
                PRESENT: begin
                    if (abort) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                    end else if (handshake) begin
                        if (is_cont || (is_scan && after_found)) begin
                            out_data_reg <= load_data_next;
                            out_ch_reg   <= load_idx_next;
                        end else begin
                            state_reg     <= DONE;
                            out_valid_reg <= 1'b0;
                            busy_reg      <= 1'b0;
                            done_reg      <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    done_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign out_data  = out_data_reg;
    assign out_ch    = out_ch_reg;
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule
